// File: rtl/td4_prog_rom.sv
// td4_prog_rom -- instruction memory responder for the TD4 CPU fetch path.
//
// The CPU presents a fetch address on pc and receives the registered
// instruction one cycle later. Contents are loaded byte-serially from the
// pin-side loader over a valid/ready port. The CPU is held stalled while a
// load is in progress.
//
// Optional feature (macro PROG_ROM_CHECKSUM_EN): after the 2**AW data bytes
// one extra checksum byte is expected. The byte sum of data plus checksum must
// be zero mod 2**DW. A bad checksum parks the block in an error state until
// load_start or rst.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset (clears memory)
//   pc         in   AW  CPU fetch address
//   instr      out  DW  registered instruction for pc (NOP_W when not running)
//   cpu_hold   out  1   1 = CPU must not advance PC
//   load_start in   1   1-cycle pulse: begin (re)load at address 0
//   wr_valid   in   1   loader has a byte on wr_data
//   wr_data    in   DW  byte to store
//   wr_ready   out  1   block accepts wr_data this cycle
//   load_done  out  1   1-cycle pulse on return to RUN after a load
//   chk_err    out  1   sticky checksum failure (0 without the feature)
module td4_prog_rom #(
   parameter int unsigned     AW    = 4,
   parameter int unsigned     DW    = 8,
   parameter logic [DW-1:0]   NOP_W = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc,
   output logic [DW-1:0] instr,
   output logic          cpu_hold,
   input  logic          load_start,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          load_done,
   output logic          chk_err
);

   localparam int unsigned DEPTH = 1 << AW;

`ifdef PROG_ROM_CHECKSUM_EN
   typedef enum logic [1:0] {S_RUN, S_LOAD, S_CHK, S_ERR} state_t;
`else
   typedef enum logic {S_RUN, S_LOAD} state_t;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] instr_q;
   logic          load_done_q;
   logic          we;
   logic [DW-1:0] mem_q [DEPTH];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      we      = 1'b0;
      case (state_q)
         S_RUN: ;
         S_LOAD: begin
            if (wr_valid) begin
               we    = 1'b1;
               sum_d = sum_q + wr_data;
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == '1) begin
`ifdef PROG_ROM_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_RUN;
`endif
               end
            end
         end
`ifdef PROG_ROM_CHECKSUM_EN
         S_CHK: begin
            if (wr_valid) begin
               state_d = ((sum_q + wr_data) == '0) ? S_RUN : S_ERR;
            end
         end
         S_ERR: ;
`endif
         default: state_d = S_RUN;
      endcase
      // A restart wins over a write presented in the same cycle.
      if (load_start) begin
         state_d = S_LOAD;
         ptr_d   = '0;
         sum_d   = '0;
         we      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         ptr_q       <= '0;
         sum_q       <= '0;
         instr_q     <= NOP_W;
         load_done_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         if (we) begin
            mem_q[ptr_q] <= wr_data;
         end
         instr_q     <= (state_q == S_RUN) ? mem_q[pc] : NOP_W;
         // Pulse on the first RUN cycle after a completed load.
         load_done_q <= (state_q != S_RUN) && (state_d == S_RUN);
      end
   end

   assign instr     = instr_q;
   assign load_done = load_done_q;
   assign cpu_hold  = (state_q != S_RUN);

`ifdef PROG_ROM_CHECKSUM_EN
   assign wr_ready  = (state_q == S_LOAD) || (state_q == S_CHK);
   assign chk_err   = (state_q == S_ERR);
`else
   assign wr_ready  = (state_q == S_LOAD);
   assign chk_err   = 1'b0;
`endif

endmodule
